operand_fwd_stage: RTL and testbench
====================================

# operand_fwd_stage

Parametrised operand-forwarding stage sitting between register-file read and the ID/EX pipeline register of the RISC-V core. For every read port it compares the source register against N prioritised in-flight writers, selects the newest value, and detects load-use hazards. It registers the resolved operands behind a valid/ready handshake. It replaces the fixed 3-input per-operand forwarding mux driven by an external 2-bit select, and generalises port count, source count and width.

## Interface
- XLEN, 32: operand width.
- REGW, 5: register-address width.
- NUM_RD, 2: read ports (rs1, rs2, ...).
- NUM_SRC, 2: forwarding sources; index 0 is the youngest (EX/MEM), index NUM_SRC-1 the oldest (MEM/WB).
- SELW, $clog2(NUM_SRC+1): per-port select width.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode slot holds an instruction.
- in_ready  out  1  stage accepts it this cycle.
- rs_addr  in  NUM_RD*REGW  packed source addresses.
- rs_used  in  NUM_RD  port actually consumed (unused ports never stall).
- rf_data  in  NUM_RD*XLEN  register-file read data.
- src_valid  in  NUM_SRC  source will write a register.
- src_rd  in  NUM_SRC*REGW  source destination address.
- src_data  in  NUM_SRC*XLEN  source result.
- src_pending  in  NUM_SRC  source result not yet available (load in flight).
- flush  in  1  kill the registered operands.
- out_valid  out  1  registered operands valid.
- out_ready  in  1  EX consumes operands.
- op_data  out  NUM_RD*XLEN  registered resolved operands.
- op_sel  out  NUM_RD*SELW  registered select per port: 0 = register file, k+1 = source k.
- hazard_stall  out  1  load-use stall (combinational).
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- Per port p: match[k] = src_valid[k] && src_rd[k]==rs_addr[p] && rs_addr[p]!=0.
- Winner is the lowest matching k. If there is no match, rf_data[p] is used (select 0).
- Address x0 always resolves to 0, regardless of rf_data or any source.
- hazard_stall = in_valid && any port p with rs_used[p] whose winning source has src_pending set. A pending older source shadowed by a non-pending younger match does not stall.
- in_ready = !hazard_stall && (!out_valid || out_ready).
- Capture on in_valid && in_ready: op_data, op_sel and out_valid are all loaded (out_valid <= 1).
- Without a capture, out_valid clears on out_ready.
- flush has priority: on the next edge out_valid=0, regardless of capture. op_data and op_sel hold their values.
- stall_cnt increments on each cycle with hazard_stall=1 and saturates at 16'hFFFF. It is never cleared except by reset.

## Timing
- Reset values: out_valid=0, op_data=0, op_sel=0, stall_cnt=0. in_ready is 1 after reset when no hazard is present.
- Latency is one cycle from capture to out_valid.
- Throughput is one instruction per cycle while out_ready=1.
- hazard_stall and in_ready are combinational from current inputs. There is no registered stall bubble; the upstream stage holds its inputs.
- Backpressure: when out_valid=1 and out_ready=0, op_data and op_sel hold stable and in_ready=0.
- Reset assertion mid-stream clears all state asynchronously. Any held instruction is lost.
- If flush and in_valid && in_ready coincide, the capture is discarded and the upstream still sees the handshake complete. Upstream must also flush its own slot.

## Configuration
- Macro: FWD_RETIRE_BYPASS_EN.
- Defined: adds a one-entry retire buffer (valid, rd, data). It loads from source NUM_SRC-1 whenever that source is valid and not pending, and resets to invalid. The buffer acts as the lowest-priority source with select value NUM_SRC+1 and widens SELW accordingly. This covers a register file without write-before-read.
- Undefined: no retire buffer. Selects range over 0..NUM_SRC only.

## Structure
- Shared package fwd_pkg: select encoding constants (FWD_SEL_RF=0, source offset 1), the default XLEN/REGW values, and the stall_cnt width.
- One sub-module, fwd_port_resolve, is instantiated NUM_RD times. Per port it does the priority match, the x0 squash, the data select and the pending flag.
- The top level holds the handshake, the output register, stall_cnt and the optional retire buffer.

## Test plan
- No match: rs=5, rf_data=32'h11, no source valid -> next cycle op_data=32'h11, op_sel=0, out_valid=1.
- Double match: src0 and src1 both rd=7, data 32'hA and 32'hB, rs=7 -> op_data=32'hA, op_sel=1.
- x0 squash: rs=0, src0 rd=0 with data 32'hFF, rf_data=32'h5 -> op_data=0.
- Load-use: src0 rd=3 pending, rs_used=1 with rs=3 -> hazard_stall=1, in_ready=0, stall_cnt increments each cycle. When pending drops, capture src0 data.
- Backpressure and flush: out_ready=0 for 3 cycles -> op_data stable, in_ready=0. Then flush=1 -> out_valid=0 next cycle.
- FWD_RETIRE_BYPASS_EN: src1 writes rd=9=32'h77, then no source valid and rf_data stale=0, rs=9 -> op_data=32'h77, op_sel=NUM_SRC+1.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg
// Shared definitions for the operand-forwarding stage:
//   - select encoding: FWD_SEL_RF (register file) and the offset added to a
//     source index to form its select value,
//   - default operand / register-address widths,
//   - width of the saturating stall counter,
//   - FWD_RETIRE_EN: 1 when the build defines FWD_RETIRE_BYPASS_EN, which adds
//     a one-entry retire buffer acting as the lowest-priority forwarding source.
package fwd_pkg;

  localparam int FWD_XLEN_DEF     = 32;
  localparam int FWD_REGW_DEF     = 5;
  localparam int FWD_STALL_CNT_W  = 16;

  // Select encoding: 0 = register file, k + FWD_SEL_SRC_OFS = candidate k.
  localparam int FWD_SEL_RF       = 0;
  localparam int FWD_SEL_SRC_OFS  = 1;

`ifdef FWD_RETIRE_BYPASS_EN
  localparam int FWD_RETIRE_EN    = 1;
`else
  localparam int FWD_RETIRE_EN    = 0;
`endif

endpackage

// File: rtl/fwd_port_resolve.sv
// fwd_port_resolve
// Resolves one operand read port against NUM_CAND prioritised forwarding
// candidates (index 0 = youngest, wins over every older match).
//   rs_addr      in   source register address of this port
//   rf_data      in   register-file read data for this port
//   cand_valid   in   candidate will write a register
//   cand_rd      in   packed candidate destination addresses
//   cand_data    in   packed candidate results
//   cand_pending in   candidate result not yet available
//   res_data     out  resolved operand (x0 always reads 0)
//   res_sel      out  0 = register file, k+1 = candidate k
//   res_pending  out  winning candidate is still pending
module fwd_port_resolve
  import fwd_pkg::*;
#(
  parameter int XLEN     = FWD_XLEN_DEF,
  parameter int REGW     = FWD_REGW_DEF,
  parameter int NUM_CAND = 2,
  parameter int SELW     = 2
) (
  input  logic [REGW-1:0]          rs_addr,
  input  logic [XLEN-1:0]          rf_data,
  input  logic [NUM_CAND-1:0]      cand_valid,
  input  logic [NUM_CAND*REGW-1:0] cand_rd,
  input  logic [NUM_CAND*XLEN-1:0] cand_data,
  input  logic [NUM_CAND-1:0]      cand_pending,
  output logic [XLEN-1:0]          res_data,
  output logic [SELW-1:0]          res_sel,
  output logic                     res_pending
);

  logic w_found;

  always_comb begin
    res_data    = rf_data;
    res_sel     = SELW'(FWD_SEL_RF);
    res_pending = 1'b0;
    w_found     = 1'b0;
    if (rs_addr == '0) begin
      // x0 is hard-wired: ignore the register file and every writer of x0.
      res_data = '0;
    end else begin
      // Scan youngest first; once a match is taken older ones are ignored,
      // so a pending older writer shadowed by a younger one never stalls.
      for (int k = 0; k < NUM_CAND; k++) begin
        if (!w_found && cand_valid[k] && (cand_rd[k*REGW +: REGW] == rs_addr)) begin
          w_found     = 1'b1;
          res_data    = cand_data[k*XLEN +: XLEN];
          res_sel     = SELW'(k + FWD_SEL_SRC_OFS);
          res_pending = cand_pending[k];
        end
      end
    end
  end

endmodule

// File: rtl/operand_fwd_stage.sv
// operand_fwd_stage
// Operand-forwarding stage between register-file read and the ID/EX register.
// Each read port is resolved against NUM_SRC in-flight writers (index 0 the
// youngest), load-use hazards are detected, and the resolved operands are
// registered behind a valid/ready handshake.
// Optional feature macro: FWD_RETIRE_BYPASS_EN adds a one-entry retire buffer
// fed from the oldest source, used as the lowest-priority candidate with
// select value NUM_SRC+1.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready is combinational)
//   rs_addr, rs_used     packed source addresses, per-port consumed flags
//   rf_data              packed register-file read data
//   src_valid/rd/data    forwarding sources
//   src_pending          source result not available yet (load in flight)
//   flush                kill the registered operands
//   out_valid/out_ready  downstream handshake
//   op_data, op_sel      registered resolved operands and per-port selects
//   hazard_stall         combinational load-use stall
//   stall_cnt            saturating count of stalled cycles
module operand_fwd_stage
  import fwd_pkg::*;
#(
  parameter int XLEN    = FWD_XLEN_DEF,
  parameter int REGW    = FWD_REGW_DEF,
  parameter int NUM_RD  = 2,
  parameter int NUM_SRC = 2,
  parameter int SELW    = $clog2(NUM_SRC + 1 + FWD_RETIRE_EN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_RD*REGW-1:0]       rs_addr,
  input  logic [NUM_RD-1:0]            rs_used,
  input  logic [NUM_RD*XLEN-1:0]       rf_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*REGW-1:0]      src_rd,
  input  logic [NUM_SRC*XLEN-1:0]      src_data,
  input  logic [NUM_SRC-1:0]           src_pending,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_RD*XLEN-1:0]       op_data,
  output logic [NUM_RD*SELW-1:0]       op_sel,
  output logic                         hazard_stall,
  output logic [FWD_STALL_CNT_W-1:0]   stall_cnt
);

  localparam int NUM_CAND = NUM_SRC + FWD_RETIRE_EN;

  logic [NUM_CAND-1:0]      w_cand_valid;
  logic [NUM_CAND*REGW-1:0] w_cand_rd;
  logic [NUM_CAND*XLEN-1:0] w_cand_data;
  logic [NUM_CAND-1:0]      w_cand_pending;

  logic [NUM_RD*XLEN-1:0]   w_res_data;
  logic [NUM_RD*SELW-1:0]   w_res_sel;
  logic [NUM_RD-1:0]        w_res_pending;

  logic                     w_capture;

  logic                       r_out_valid;
  logic [NUM_RD*XLEN-1:0]     r_op_data;
  logic [NUM_RD*SELW-1:0]     r_op_sel;
  logic [FWD_STALL_CNT_W-1:0] r_stall_cnt;

`ifdef FWD_RETIRE_BYPASS_EN
  // Retire buffer: remembers the last completed write of the oldest source so
  // a register file without write-before-read still returns the new value.
  logic            r_ret_valid;
  logic [REGW-1:0] r_ret_rd;
  logic [XLEN-1:0] r_ret_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_valid <= 1'b0;
      r_ret_rd    <= '0;
      r_ret_data  <= '0;
    end else if (src_valid[NUM_SRC-1] && !src_pending[NUM_SRC-1]) begin
      r_ret_valid <= 1'b1;
      r_ret_rd    <= src_rd[(NUM_SRC-1)*REGW +: REGW];
      r_ret_data  <= src_data[(NUM_SRC-1)*XLEN +: XLEN];
    end
  end

  // Buffer occupies the top (lowest-priority) candidate slot; never pending.
  assign w_cand_valid   = {r_ret_valid, src_valid};
  assign w_cand_rd      = {r_ret_rd, src_rd};
  assign w_cand_data    = {r_ret_data, src_data};
  assign w_cand_pending = {1'b0, src_pending};
`else
  assign w_cand_valid   = src_valid;
  assign w_cand_rd      = src_rd;
  assign w_cand_data    = src_data;
  assign w_cand_pending = src_pending;
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_resolve #(
      .XLEN     (XLEN),
      .REGW     (REGW),
      .NUM_CAND (NUM_CAND),
      .SELW     (SELW)
    ) u_resolve (
      .rs_addr      (rs_addr[p*REGW +: REGW]),
      .rf_data      (rf_data[p*XLEN +: XLEN]),
      .cand_valid   (w_cand_valid),
      .cand_rd      (w_cand_rd),
      .cand_data    (w_cand_data),
      .cand_pending (w_cand_pending),
      .res_data     (w_res_data[p*XLEN +: XLEN]),
      .res_sel      (w_res_sel[p*SELW +: SELW]),
      .res_pending  (w_res_pending[p])
    );
  end

  // Handshake: a transfer happens on a clock edge where valid && ready are
  // both high. Upstream holds in_valid and its operands until it sees
  // in_ready; downstream sees op_data/op_sel stable while out_valid && !out_ready.
  // Only consumed ports can raise a load-use stall.
  assign hazard_stall = in_valid && |(rs_used & w_res_pending);
  assign in_ready     = !hazard_stall && (!r_out_valid || out_ready);
  assign w_capture    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_op_data   <= '0;
      r_op_sel    <= '0;
    end else begin
      // flush wins: a coinciding capture completes upstream but is dropped here.
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_capture) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_capture && !flush) begin
        r_op_data <= w_res_data;
        r_op_sel  <= w_res_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (hazard_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign op_data   = r_op_data;
  assign op_sel    = r_op_sel;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// tb_operand_fwd_stage
// Scoreboard bench for operand_fwd_stage. The driver issues one input set per
// cycle and, from a reference model of the forwarding rules, pushes the
// operand set the output register must hold into exp_q. A separate monitor on
// the falling edge compares out_valid, op_data/op_sel and stall_cnt.
// Honours FWD_RETIRE_BYPASS_EN when the build defines it.
module tb_operand_fwd_stage;

  localparam int XLEN    = 32;
  localparam int REGW    = 5;
  localparam int NUM_RD  = 2;
  localparam int NUM_SRC = 2;
`ifdef FWD_RETIRE_BYPASS_EN
  localparam int RET     = 1;
`else
  localparam int RET     = 0;
`endif
  localparam int SELW    = $clog2(NUM_SRC + 1 + RET);
  localparam int W       = NUM_RD*XLEN + NUM_RD*SELW;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_RD*REGW-1:0]  rs_addr;
  logic [NUM_RD-1:0]       rs_used;
  logic [NUM_RD*XLEN-1:0]  rf_data;
  logic [NUM_SRC-1:0]      src_valid;
  logic [NUM_SRC*REGW-1:0] src_rd;
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [NUM_SRC-1:0]      src_pending;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_RD*XLEN-1:0]  op_data;
  logic [NUM_RD*SELW-1:0]  op_sel;
  logic                    hazard_stall;
  logic [15:0]             stall_cnt;

  operand_fwd_stage #(
    .XLEN(XLEN), .REGW(REGW), .NUM_RD(NUM_RD), .NUM_SRC(NUM_SRC), .SELW(SELW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rs_used(rs_used), .rf_data(rf_data),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
    .src_pending(src_pending), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op_data(op_data), .op_sel(op_sel),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0]            exp_q[$];
  int                      n_checks;
  int                      n_fail;
  int                      exp_stall;
  logic                    mon_en;
  logic                    ret_v;
  logic [REGW-1:0]         ret_rd;
  logic [XLEN-1:0]         ret_d;
  logic                    prev_cap;
  logic                    prev_flush;
  logic                    prev_haz;
  logic [W-1:0]            prev_exp;
  logic [NUM_SRC-1:0]      prev_sv;
  logic [NUM_SRC*REGW-1:0] prev_srd;
  logic [NUM_SRC*XLEN-1:0] prev_sd;
  logic [NUM_SRC-1:0]      prev_sp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rule for one port: x0 reads 0; otherwise the youngest source
  // writing that register supplies the value, then the retire buffer, then RF.
  function automatic void model_port(input logic [REGW-1:0] rs, input logic [XLEN-1:0] rf,
                                     output logic [XLEN-1:0] d, output logic [SELW-1:0] s,
                                     output logic pend);
    d = rf; s = '0; pend = 1'b0;
    if (rs == 0) begin
      d = '0;
      return;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_valid[k] && src_rd[k*REGW +: REGW] == rs) begin
        d = src_data[k*XLEN +: XLEN];
        s = SELW'(k + 1);
        pend = src_pending[k];
        return;
      end
    end
    if (RET != 0 && ret_v && ret_rd == rs) begin
      d = ret_d;
      s = SELW'(NUM_SRC + 1);
    end
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_stall  = 0;
    ret_v      = 1'b0;
    ret_rd     = '0;
    ret_d      = '0;
    prev_cap   = 1'b0;
    prev_flush = 1'b0;
    prev_haz   = 1'b0;
    prev_exp   = '0;
    prev_sv    = '0;
    prev_srd   = '0;
    prev_sd    = '0;
    prev_sp    = '0;
  endtask

  // Effects of the clock edge that just passed, from last cycle's inputs.
  task automatic apply_prev();
    if (prev_flush) exp_q.delete();
    else if (prev_cap) exp_q.push_back(prev_exp);
    if (prev_haz && exp_stall < 65535) exp_stall++;
    if (RET != 0 && prev_sv[NUM_SRC-1] && !prev_sp[NUM_SRC-1]) begin
      ret_v  = 1'b1;
      ret_rd = prev_srd[(NUM_SRC-1)*REGW +: REGW];
      ret_d  = prev_sd[(NUM_SRC-1)*XLEN +: XLEN];
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic iv, input logic [NUM_RD*REGW-1:0] rs,
                             input logic [NUM_RD-1:0] used, input logic [NUM_RD*XLEN-1:0] rf,
                             input logic [NUM_SRC-1:0] sv, input logic [NUM_SRC*REGW-1:0] srd,
                             input logic [NUM_SRC*XLEN-1:0] sd, input logic [NUM_SRC-1:0] sp,
                             input logic fl, input logic ordy);
    logic [NUM_RD*XLEN-1:0] ed;
    logic [NUM_RD*SELW-1:0] es;
    logic [XLEN-1:0]        d;
    logic [SELW-1:0]        s;
    logic                   pend;
    logic                   haz;
    logic                   rdy;
    @(posedge clk);
    #1;
    apply_prev();
    in_valid    = iv;
    rs_addr     = rs;
    rs_used     = used;
    rf_data     = rf;
    src_valid   = sv;
    src_rd      = srd;
    src_data    = sd;
    src_pending = sp;
    flush       = fl;
    out_ready   = fl ? 1'b0 : ordy;
    #1;
    haz = 1'b0;
    ed  = '0;
    es  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      model_port(rs[p*REGW +: REGW], rf[p*XLEN +: XLEN], d, s, pend);
      ed[p*XLEN +: XLEN] = d;
      es[p*SELW +: SELW] = s;
      if (used[p] && pend) haz = 1'b1;
    end
    haz = iv && haz;
    rdy = !haz && (exp_q.size() == 0 || out_ready);
    check("hazard_stall", 128'(hazard_stall), 128'(haz));
    check("in_ready", 128'(in_ready), 128'(rdy));
    prev_cap   = iv && rdy && !fl;
    prev_flush = fl;
    prev_haz   = haz;
    prev_exp   = {ed, es};
    prev_sv    = sv;
    prev_srd   = srd;
    prev_sd    = sd;
    prev_sp    = sp;
  endtask

  task automatic drive_idle(input logic ordy);
    drive_cycle(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, ordy);
  endtask

  task automatic drive_random();
    logic [NUM_RD*REGW-1:0]  rs;
    logic [NUM_RD*XLEN-1:0]  rf;
    logic [NUM_SRC*REGW-1:0] srd;
    logic [NUM_SRC*XLEN-1:0] sd;
    logic [NUM_SRC-1:0]      sp;
    for (int p = 0; p < NUM_RD; p++) begin
      rs[p*REGW +: REGW] = REGW'($urandom_range(0, 7));
      rf[p*XLEN +: XLEN] = $urandom;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      srd[k*REGW +: REGW] = REGW'($urandom_range(0, 7));
      sd[k*XLEN +: XLEN]  = $urandom;
      sp[k]               = ($urandom_range(0, 3) == 0);
    end
    drive_cycle($urandom_range(0, 3) != 0, rs, NUM_RD'($urandom), rf,
                NUM_SRC'($urandom), srd, sd, sp,
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      check("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
      if (out_valid && exp_q.size() != 0) begin
        check("op_data_sel", 128'({op_data, op_sel}), 128'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    clear_model();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    rs_addr     = '0;
    rs_used     = '0;
    rf_data     = '0;
    src_valid   = '0;
    src_rd      = '0;
    src_data    = '0;
    src_pending = '0;
    flush       = 1'b0;
    out_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_op_data", 128'(op_data), 128'(0));
    check("rst_op_sel", 128'(op_sel), 128'(0));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    mon_en = 1'b1;

    // No match: rf_data passes through with select 0.
    drive_cycle(1'b1, {5'd0, 5'd5}, 2'b01, {32'h0, 32'h11}, 2'b00, '0, '0, '0, 1'b0, 1'b1);
    // Double match: youngest source wins.
    drive_cycle(1'b1, {5'd0, 5'd7}, 2'b01, {32'h0, 32'h0}, 2'b11, {5'd7, 5'd7},
                {32'hB, 32'hA}, 2'b00, 1'b0, 1'b1);
    // x0 squash on both ports.
    drive_cycle(1'b1, {5'd0, 5'd0}, 2'b11, {32'h5, 32'h5}, 2'b01, {5'd0, 5'd0},
                {32'h0, 32'hFF}, 2'b00, 1'b0, 1'b1);
    // Load-use stall for three cycles, then the load result forwards.
    repeat (3)
      drive_cycle(1'b1, {5'd0, 5'd3}, 2'b01, {32'h0, 32'h1}, 2'b01, {5'd0, 5'd3},
                  {32'h0, 32'h0}, 2'b01, 1'b0, 1'b1);
    drive_cycle(1'b1, {5'd0, 5'd3}, 2'b01, {32'h0, 32'h1}, 2'b01, {5'd0, 5'd3},
                {32'h0, 32'h33}, 2'b00, 1'b0, 1'b1);
    // Pending older source shadowed by a ready younger one: no stall.
    drive_cycle(1'b1, {5'd4, 5'd0}, 2'b10, {32'h0, 32'h0}, 2'b11, {5'd4, 5'd4},
                {32'h44, 32'h40}, 2'b10, 1'b0, 1'b1);
    // Pending source on an unused port: no stall.
    drive_cycle(1'b1, {5'd6, 5'd0}, 2'b01, {32'h0, 32'h0}, 2'b01, {5'd0, 5'd6},
                {32'h0, 32'h66}, 2'b01, 1'b0, 1'b1);
    drive_idle(1'b1);
    // Backpressure: capture, hold 3 cycles, then flush.
    drive_cycle(1'b1, {5'd2, 5'd1}, 2'b11, {32'h22, 32'h21}, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    repeat (3)
      drive_cycle(1'b1, {5'd5, 5'd6}, 2'b11, {32'h55, 32'h56}, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, {5'd5, 5'd6}, 2'b11, {32'h55, 32'h56}, 2'b00, '0, '0, '0, 1'b1, 1'b0);
    // Flush coinciding with a capture: the capture is dropped.
    drive_cycle(1'b1, {5'd5, 5'd6}, 2'b11, {32'h55, 32'h56}, 2'b00, '0, '0, '0, 1'b1, 1'b0);
    drive_idle(1'b1);
    // Retire bypass: oldest source writes x9, later read with stale RF.
    drive_cycle(1'b0, '0, '0, '0, 2'b10, {5'd9, 5'd0}, {32'h77, 32'h0}, 2'b00, 1'b0, 1'b1);
    drive_cycle(1'b1, {5'd0, 5'd9}, 2'b01, {32'h0, 32'h0}, 2'b00, '0, '0, '0, 1'b0, 1'b1);
    drive_idle(1'b1);

    repeat (400) drive_random();

    // Asynchronous reset in mid-stream.
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_stall_cnt", 128'(stall_cnt), 128'(0));
    check("mid_rst_op_data", 128'(op_data), 128'(0));
    clear_model();
    in_valid  = 1'b0;
    src_valid = '0;
    flush     = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    repeat (200) drive_random();
    repeat (4) drive_idle(1'b1);
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
